// File: rtl/menu_controller_pkg.sv
// Shared definitions for the menu controller: FSM state encoding,
// display page codes and the browse-page advance helper.
package menu_controller_pkg;

    typedef enum logic [1:0] {
        BROWSE      = 2'd0,
        EDIT_PERSON = 2'd1,
        EDIT_ROOM   = 2'd2
    } menu_state_t;

    localparam logic [7:0] PAGE_FIRST       = 8'd0;
    localparam logic [7:0] PAGE_LAST        = 8'd7;
    localparam logic [7:0] PAGE_PERSON      = 8'd4;
    localparam logic [7:0] PAGE_ROOM        = 8'd5;
    localparam logic [7:0] PAGE_PERSON_EDIT = 8'd20;
    localparam logic [7:0] PAGE_ROOM_EDIT   = 8'd21;

    // Browse pages cycle 0..PAGE_LAST and wrap back to the first page.
    function automatic logic [7:0] next_page(input logic [7:0] page);
        if (page >= PAGE_LAST)
            return PAGE_FIRST;
        return page + 8'd1;
    endfunction

endpackage

// File: rtl/menu_controller_key_debounce.sv
// One pushbutton: 2-flop synchronizer, counting debouncer, press edge.
// Ports: Clock, Reset (sync, active-high), key_n (raw, active-low),
//        press (one-cycle pulse when the debounced key becomes pressed).
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic Clock,
    input  logic Reset,
    input  logic key_n,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_a;
    logic          sync_b;
    logic          stable;
    logic [CW-1:0] count;
    logic          raw_pressed;
    logic          differ;
    logic          accept;

    assign raw_pressed = ~sync_b;
    assign differ      = raw_pressed != stable;
    assign accept      = differ && (count == LAST);

    // The synchronizer resets to the released (high) level so a key held
    // through reset is seen as a fresh press once it has been stable.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
        end else begin
            sync_a <= key_n;
            sync_b <= sync_a;
        end
    end

    // Any cycle where the synchronized level matches the stable level
    // restarts the count, so bounces never accumulate.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            stable <= 1'b0;
            count  <= '0;
            press  <= 1'b0;
        end else begin
            press <= accept && raw_pressed;
            if (!differ) begin
                count <= '0;
            end else if (accept) begin
                stable <= raw_pressed;
                count  <= '0;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/menu_controller.sv
// Three-key menu controller: browse pages, enter/leave edit pages,
// and emit increment pulses while editing.
// Ports: Clock, Reset (sync, active-high), KeyNext_n/KeySelect_n/KeyUp_n
//        (raw active-low buttons), Selector (page code), Increment
//        (one-cycle pulse per Up in edit), EditMode (high in edit states).
module menu_controller
    import menu_controller_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       KeyNext_n,
    input  logic       KeySelect_n,
    input  logic       KeyUp_n,
    output logic [7:0] Selector,
    output logic       Increment,
    output logic       EditMode
);

    logic        next_press;
    logic        select_press;
    logic        up_press;
    logic        do_select;
    logic        do_next;
    logic        do_up;
    menu_state_t state;
    menu_state_t state_next;
    logic [7:0]  selector_next;
    logic        increment_next;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
        .Clock (Clock),
        .Reset (Reset),
        .key_n (KeyNext_n),
        .press (next_press)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_select (
        .Clock (Clock),
        .Reset (Reset),
        .key_n (KeySelect_n),
        .press (select_press)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
        .Clock (Clock),
        .Reset (Reset),
        .key_n (KeyUp_n),
        .press (up_press)
    );

    // Priority masking: at most one press is acted on per cycle.
    assign do_select = select_press;
    assign do_next   = next_press & ~select_press;
    assign do_up     = up_press & ~next_press & ~select_press;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= BROWSE;
            Selector  <= PAGE_FIRST;
            Increment <= 1'b0;
            EditMode  <= 1'b0;
        end else begin
            state     <= state_next;
            Selector  <= selector_next;
            Increment <= increment_next;
            EditMode  <= (state_next != BROWSE);
        end
    end

    always_comb begin
        state_next     = state;
        selector_next  = Selector;
        increment_next = 1'b0;
        unique case (1'b1)
            do_select: begin
                unique case (state)
                    BROWSE: begin
                        if (Selector == PAGE_PERSON) begin
                            state_next    = EDIT_PERSON;
                            selector_next = PAGE_PERSON_EDIT;
                        end else if (Selector == PAGE_ROOM) begin
                            state_next    = EDIT_ROOM;
                            selector_next = PAGE_ROOM_EDIT;
                        end
                    end
                    EDIT_PERSON: begin
                        state_next    = BROWSE;
                        selector_next = PAGE_PERSON;
                    end
                    EDIT_ROOM: begin
                        state_next    = BROWSE;
                        selector_next = PAGE_ROOM;
                    end
                    default: begin
                        state_next    = BROWSE;
                        selector_next = PAGE_FIRST;
                    end
                endcase
            end
            do_next: begin
                if (state == BROWSE)
                    selector_next = next_page(Selector);
            end
            do_up: begin
                increment_next = (state != BROWSE);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_menu_controller.sv
// Testbench for menu_controller with DEBOUNCE_CYCLES=4: vector table,
// hand-written corner sequences and random presses against a page model.
module tb_menu_controller;

    localparam int DB = 4;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       KeyNext_n = 1'b1;
    logic       KeySelect_n = 1'b1;
    logic       KeyUp_n = 1'b1;
    logic [7:0] Selector;
    logic       Increment;
    logic       EditMode;

    int checks = 0;
    int failures = 0;
    int inc_cnt = 0;
    int inc_wide = 0;
    logic inc_prev = 1'b0;

    menu_controller #(.DEBOUNCE_CYCLES(DB)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .KeyNext_n   (KeyNext_n),
        .KeySelect_n (KeySelect_n),
        .KeyUp_n     (KeyUp_n),
        .Selector    (Selector),
        .Increment   (Increment),
        .EditMode    (EditMode)
    );

    always #5 Clock = ~Clock;

    always @(negedge Clock) begin
        if (Increment) inc_cnt++;
        if (Increment && inc_prev) inc_wide++;
        inc_prev = Increment;
    end

    // keys bit order: {select, next, up}
    typedef struct {
        logic [2:0] keys;
        logic [7:0] sel;
        logic       edit;
        int         inc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [2:0] k, logic [7:0] s, logic e, int i);
        vec_t v;
        v.keys = k;
        v.sel = s;
        v.edit = e;
        v.inc = i;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge Clock);
        Reset = 1'b1;
        KeyNext_n = 1'b1;
        KeySelect_n = 1'b1;
        KeyUp_n = 1'b1;
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        repeat (2) @(negedge Clock);
    endtask

    task automatic press(input logic [2:0] k, input int hold);
        @(negedge Clock);
        KeySelect_n = ~k[2];
        KeyNext_n = ~k[1];
        KeyUp_n = ~k[0];
        repeat (hold) @(negedge Clock);
        KeySelect_n = 1'b1;
        KeyNext_n = 1'b1;
        KeyUp_n = 1'b1;
        repeat (12) @(negedge Clock);
    endtask

    task automatic next_pulse(input int lo, input int hi);
        KeyNext_n = 1'b0;
        repeat (lo) @(negedge Clock);
        KeyNext_n = 1'b1;
        repeat (hi) @(negedge Clock);
    endtask

    initial begin
        int base;
        int lat;
        int page;
        int exp_inc;
        logic [7:0] old;
        logic [2:0] k;

        // 8 Next presses step 1..7,0
        for (int i = 1; i <= 8; i++)
            tbl.push_back(mk(3'b010, 8'(i % 8), 1'b0, 0));
        for (int i = 1; i <= 4; i++)
            tbl.push_back(mk(3'b010, 8'(i), 1'b0, 0));
        tbl.push_back(mk(3'b100, 8'd20, 1'b1, 0));
        tbl.push_back(mk(3'b001, 8'd20, 1'b1, 1));
        tbl.push_back(mk(3'b001, 8'd20, 1'b1, 1));
        tbl.push_back(mk(3'b001, 8'd20, 1'b1, 1));
        tbl.push_back(mk(3'b010, 8'd20, 1'b1, 0));
        tbl.push_back(mk(3'b100, 8'd4, 1'b0, 0));
        tbl.push_back(mk(3'b001, 8'd4, 1'b0, 0));
        tbl.push_back(mk(3'b010, 8'd5, 1'b0, 0));
        tbl.push_back(mk(3'b110, 8'd21, 1'b1, 0));
        tbl.push_back(mk(3'b001, 8'd21, 1'b1, 1));
        tbl.push_back(mk(3'b101, 8'd5, 1'b0, 0));
        tbl.push_back(mk(3'b010, 8'd6, 1'b0, 0));
        tbl.push_back(mk(3'b010, 8'd7, 1'b0, 0));
        tbl.push_back(mk(3'b010, 8'd0, 1'b0, 0));
        tbl.push_back(mk(3'b010, 8'd1, 1'b0, 0));
        tbl.push_back(mk(3'b010, 8'd2, 1'b0, 0));
        tbl.push_back(mk(3'b100, 8'd2, 1'b0, 0));
        tbl.push_back(mk(3'b001, 8'd2, 1'b0, 0));

        // Reset state, checked while Reset is held
        repeat (3) @(negedge Clock);
        check("reset_sel", Selector, 0);
        check("reset_edit", EditMode, 0);
        check("reset_inc", Increment, 0);
        Reset = 1'b0;
        repeat (2) @(negedge Clock);

        for (int i = 0; i < tbl.size(); i++) begin
            base = inc_cnt;
            press(tbl[i].keys, 10);
            check($sformatf("tbl%0d_sel", i), Selector, tbl[i].sel);
            check($sformatf("tbl%0d_edit", i), EditMode, tbl[i].edit);
            check($sformatf("tbl%0d_inc", i), inc_cnt - base, tbl[i].inc);
        end

        // Latency from a clean key edge: 2 + DB + 1, +/-1
        @(negedge Clock);
        old = Selector;
        KeyNext_n = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge Clock);
            #1;
            if (Selector != old) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) begin
            check("latency_timeout", 0, 1);
        end else begin
            checks++;
            if (lat < DB + 2 || lat > DB + 4) begin
                failures++;
                $display("FAIL latency: got %0d expected %0d+/-1", lat, DB + 3);
            end
        end
        check("latency_sel", Selector, 3);
        repeat (4) @(negedge Clock);
        KeyNext_n = 1'b1;
        repeat (12) @(negedge Clock);

        // Bouncing Next press, then held: one increment 0->1
        do_reset();
        check("bounce_pre", Selector, 0);
        next_pulse(2, 2);
        next_pulse(1, 3);
        next_pulse(3, 1);
        next_pulse(2, 2);
        KeyNext_n = 1'b0;
        repeat (40) @(negedge Clock);
        KeyNext_n = 1'b1;
        repeat (12) @(negedge Clock);
        check("bounce_sel", Selector, 1);

        // Held key: exactly one press, no auto-repeat
        press(3'b010, 60);
        check("hold_sel", Selector, 2);

        // Reset during an Up press in EDIT_ROOM
        press(3'b010, 10);
        press(3'b010, 10);
        press(3'b010, 10);
        press(3'b100, 10);
        check("room_sel", Selector, 21);
        check("room_edit", EditMode, 1);
        base = inc_cnt;
        @(negedge Clock);
        KeyUp_n = 1'b0;
        repeat (DB + 2) @(negedge Clock);
        Reset = 1'b1;
        repeat (3) @(negedge Clock);
        check("rst_edit_sel", Selector, 0);
        check("rst_edit_mode", EditMode, 0);
        Reset = 1'b0;
        repeat (20) @(negedge Clock);
        KeyUp_n = 1'b1;
        repeat (12) @(negedge Clock);
        check("rst_edit_inc", inc_cnt - base, 0);
        check("rst_after_sel", Selector, 0);
        check("rst_after_edit", EditMode, 0);

        // Random presses against a page model
        do_reset();
        page = 0;
        for (int n = 0; n < 60; n++) begin
            k = 3'($urandom_range(1, 7));
            exp_inc = 0;
            if (k[2]) begin
                if (page == 4) page = 20;
                else if (page == 5) page = 21;
                else if (page == 20) page = 4;
                else if (page == 21) page = 5;
            end else if (k[1]) begin
                if (page < 20) page = (page + 1) % 8;
            end else if (k[0]) begin
                if (page >= 20) exp_inc = 1;
            end
            base = inc_cnt;
            press(k, $urandom_range(8, 20));
            check($sformatf("rnd%0d_sel", n), Selector, page);
            check($sformatf("rnd%0d_edit", n), EditMode, (page >= 20) ? 1 : 0);
            check($sformatf("rnd%0d_inc", n), inc_cnt - base, exp_inc);
        end

        check("inc_single_cycle", inc_wide, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
